// File: rtl/alu_unit.sv
// Sequential ALU: single-cycle logic/arith ops plus an iterative
// shift-add multiply, driving the C bus with registered zero/carry flags.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             accept alu_op/a_in/b_in on this edge (IDLE/DONE only)
//   alu_op            operation code
//   a_in, b_in        operands A (accumulator) and B (mux output)
//   c_bus_out         registered result, held until the next completion
//   busy              high while a multiply iterates
//   done              result/flags valid this cycle
//   z_flag, c_flag    registered zero and carry/borrow/overflow flags
module alu_unit #(
    parameter int DATA_LEN = 16,
    parameter int OP_LEN   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [OP_LEN-1:0]   alu_op,
    input  logic [DATA_LEN-1:0] a_in,
    input  logic [DATA_LEN-1:0] b_in,
    output logic [DATA_LEN-1:0] c_bus_out,
    output logic                busy,
    output logic                done,
    output logic                z_flag,
    output logic                c_flag
);

    localparam int W  = DATA_LEN;
    localparam int CW = $clog2(DATA_LEN + 1);

    localparam logic [OP_LEN-1:0] OP_PASSB = OP_LEN'(0);
    localparam logic [OP_LEN-1:0] OP_ADD   = OP_LEN'(1);
    localparam logic [OP_LEN-1:0] OP_SUB   = OP_LEN'(2);
    localparam logic [OP_LEN-1:0] OP_AND   = OP_LEN'(3);
    localparam logic [OP_LEN-1:0] OP_OR    = OP_LEN'(4);
    localparam logic [OP_LEN-1:0] OP_XOR   = OP_LEN'(5);
    localparam logic [OP_LEN-1:0] OP_SHL   = OP_LEN'(6);
    localparam logic [OP_LEN-1:0] OP_SHR   = OP_LEN'(7);
    localparam logic [OP_LEN-1:0] OP_MUL   = OP_LEN'(8);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t         state_q;
    logic [2*W-1:0] mcand_q;
    logic [W-1:0]   mplier_q;
    logic [2*W-1:0] acc_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   res_q;
    logic           z_q;
    logic           c_q;

    logic [W-1:0]   res_d;
    logic           c_d;
    logic [W:0]     sum;
    logic [2*W-1:0] acc_d;

    assign sum = {1'b0, a_in} + {1'b0, b_in};

    // Accumulator value after this iteration; also used on the last
    // iteration so the final add lands in the result the same edge.
    assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        res_d = '0;
        c_d   = 1'b0;
        case (alu_op)
            OP_PASSB: res_d = b_in;
            OP_ADD: begin
                res_d = sum[W-1:0];
                c_d   = sum[W];
            end
            OP_SUB: begin
                res_d = a_in - b_in;
                c_d   = (a_in < b_in);
            end
            OP_AND: res_d = a_in & b_in;
            OP_OR:  res_d = a_in | b_in;
            OP_XOR: res_d = a_in ^ b_in;
            OP_SHL: begin
                res_d = {a_in[W-2:0], 1'b0};
                c_d   = a_in[W-1];
            end
            OP_SHR: begin
                res_d = {1'b0, a_in[W-1:1]};
                c_d   = a_in[0];
            end
            default: begin
                res_d = '0;
                c_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (alu_op == OP_MUL) begin
                            mcand_q  <= {{W{1'b0}}, a_in};
                            mplier_q <= b_in;
                            acc_q    <= '0;
                            cnt_q    <= CW'(DATA_LEN);
                            state_q  <= S_MUL;
                        end else begin
                            res_q   <= res_d;
                            z_q     <= (res_d == '0);
                            c_q     <= c_d;
                            state_q <= S_DONE;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        res_q   <= acc_d[W-1:0];
                        z_q     <= (acc_d[W-1:0] == '0);
                        c_q     <= |acc_d[2*W-1:W];
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state_q == S_MUL);
    assign done      = (state_q == S_DONE);
    assign c_bus_out = res_q;
    assign z_flag    = z_q;
    assign c_flag    = c_q;

endmodule
